im_loader: RTL and testbench

//  Program loader upstream of the mips core. Takes 32-bit instruction words over a valid/ready

---
 rtl/im_loader_pkg.sv | 21 ++
 rtl/im_byte_serializer.sv | 55 +++++
 rtl/im_loader.sv | 172 +++++++++++++++++
 tb/tb_im_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared types for the instruction-memory program loader.
// The loader's state encodings are fixed 3-bit values so they can be
// decoded by external debug logic. Byte index 0 of the instruction memory
// corresponds to the core's code-segment start PC.
package im_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_ACCEPT = 3'd1,
        LDR_WRITE  = 3'd2,
        LDR_HOLD   = 3'd3,
        LDR_RUN    = 3'd4,
        LDR_ERR    = 3'd5
    } ldr_state_t;

    // A load is in progress from the first accept slot until the core is released.
    function automatic logic is_loading(input ldr_state_t s);
        return (s == LDR_ACCEPT) || (s == LDR_WRITE) || (s == LDR_HOLD);
    endfunction

endpackage

// File: rtl/im_byte_serializer.sv
// Splits one 32-bit instruction word into four big-endian byte writes on
// consecutive cycles. The write port outputs are registered; last_byte is
// high during the cycle whose edge commits the fourth byte.
module im_byte_serializer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [31:0]       data,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wbyte,
    output logic              last_byte
);

    logic [23:0] rest;
    logic [1:0]  idx;

    // Write-port registers: start on load at the word's base address, step one byte per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wbyte <= '0;
            idx      <= '0;
        end else if (load) begin
            im_we    <= 1'b1;
            im_addr  <= base_addr;
            im_wbyte <= data[31:24];
            idx      <= '0;
        end else if (im_we) begin
            if (idx == 2'd3) begin
                im_we <= 1'b0;
            end else begin
                im_addr  <= im_addr + 1'b1;
                im_wbyte <= rest[23:16];
                idx      <= idx + 1'b1;
            end
        end
    end

    // Remaining lower bytes of the latched word, shifted up as each byte goes out.
    always_ff @(posedge clk) begin
        if (load) begin
            rest <= data[23:0];
        end else if (im_we) begin
            rest <= {rest[15:0], 8'h00};
        end
    end

    assign last_byte = im_we && (idx == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Program loader in front of the mips core: accepts instruction words on a
// valid/ready stream, writes them big-endian into the instruction memory
// and holds the core in reset until the program is complete.
// Optional feature: define IM_LOADER_CHECKSUM_EN to add a 32-bit running
// sum of the accepted words on the checksum port.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int IM_BYTES     = 1024,
    parameter int ADDR_W       = 10,
    parameter int CPU_RST_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wbyte,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_cnt
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(IM_BYTES / 4);
    localparam int HOLD_W = (CPU_RST_HOLD > 1) ? $clog2(CPU_RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CPU_RST_HOLD - 1);

    ldr_state_t        state, state_nx;
    logic              ser_load;
    logic              start_acc;
    logic              last_byte;
    logic              last_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADDR_W-1:0] word_cnt_inc;
    logic [ADDR_W-1:0] base_addr;

    assign word_cnt_inc = word_cnt + 1'b1;
    assign base_addr    = {word_cnt[ADDR_W-3:0], 2'b00};

    im_byte_serializer #(
        .ADDR_W (ADDR_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .data      (s_data),
        .base_addr (base_addr),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wbyte  (im_wbyte),
        .last_byte (last_byte)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LDR_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start only matters when no load is in progress.
    always_comb begin
        state_nx  = state;
        ser_load  = 1'b0;
        start_acc = 1'b0;
        case (state)
            LDR_IDLE, LDR_RUN, LDR_ERR: begin
                if (start) begin
                    state_nx  = LDR_ACCEPT;
                    start_acc = 1'b1;
                end
            end
            LDR_ACCEPT: begin
                if (s_valid && s_ready) begin
                    state_nx = LDR_WRITE;
                    ser_load = 1'b1;
                end
            end
            LDR_WRITE: begin
                if (last_byte) begin
                    if (last_q) begin
                        state_nx = LDR_HOLD;
                    end else if (word_cnt_inc == WORDS) begin
                        state_nx = LDR_ERR;
                    end else begin
                        state_nx = LDR_ACCEPT;
                    end
                end
            end
            LDR_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nx = LDR_RUN;
                end
            end
            default: state_nx = LDR_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            s_ready  <= (state_nx == LDR_ACCEPT);
            busy     <= is_loading(state_nx);
            cpu_rst  <= (state_nx != LDR_RUN);
            done     <= (state_nx == LDR_RUN);
            overflow <= (state_nx == LDR_ERR);
        end
    end

    // Word counter: cleared on an accepted start, bumped as each word's last byte commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
        end else if (start_acc) begin
            word_cnt <= '0;
        end else if ((state == LDR_WRITE) && last_byte) begin
            word_cnt <= word_cnt_inc;
        end
    end

    // Remember whether the word being written closes the program.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b0;
        end else if (ser_load) begin
            last_q <= s_last;
        end
    end

    // Core-release timer: preloaded outside HOLD, counts down while in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= HOLD_INIT;
        end else if (state != LDR_HOLD) begin
            hold_cnt <= HOLD_INIT;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    // Running modulo-2^32 sum of accepted words, restarted with each load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (start_acc) begin
            checksum <= '0;
        end else if (ser_load) begin
            checksum <= checksum + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader with a 16-byte instruction memory.
// Expected byte writes are queued at each accepted handshake and compared
// against the DUT write port as it produces them.
module tb_im_loader;

    localparam int IM_BYTES = 16;
    localparam int ADDR_W   = 4;
    localparam int HOLD     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic [31:0]       s_data = '0;
    logic              s_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [7:0]        im_wbyte;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] word_cnt;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    im_loader #(
        .IM_BYTES     (IM_BYTES),
        .ADDR_W       (ADDR_W),
        .CPU_RST_HOLD (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wbyte (im_wbyte),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .word_cnt (word_cnt)
`ifdef IM_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  im [0:IM_BYTES-1];
    logic [31:0] q_exp [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          exp_wc = 0;
    logic [31:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural instruction memory fed by the DUT write port.
    always @(posedge clk) begin
        if (rst && im_we) im[im_addr] <= im_wbyte;
    end

    // Scoreboard: every observed write must be the next expected {addr, byte}.
    always @(negedge clk) begin
        if (rst && im_we) begin
            last_we_cyc = cyc;
            if (q_exp.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = q_exp.pop_front();
                chk("im_write", {20'd0, im_addr, im_wbyte}, mon_e);
            end
        end
    end

    function automatic logic [31:0] im_word(input int a);
        return {im[a], im[a+1], im[a+2], im[a+3]};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_wc = 0;
    endtask

    // Offer one word; returns at the negedge after the handshake edge.
    task automatic send(input logic [31:0] d, input logic last, input bit gap);
        int t = 0;
        if (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            q_exp.push_back(32'(((4 * exp_wc + i) << 8)) | ((d >> (8 * (3 - i))) & 32'hFF));
        end
        exp_wc++;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q_exp.size() != 0 || im_we) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", q_exp.size(), 32'd0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int t;
        int rd;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {10'd0, s_ready, im_we, im_addr, im_wbyte, cpu_rst, busy, done, overflow, word_cnt},
            {10'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Single word with last, release latency
        pulse_start();
        chk("accept_ready", {31'd0, s_ready}, 32'd1);
        chk("accept_busy", {31'd0, busy}, 32'd1);
        send(32'h01095021, 1'b1, 1'b0);
        drain();
        t = 0;
        while (cpu_rst && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("release_latency", 32'(cyc - last_we_cyc), 32'(HOLD + 1));
        chk("single_word_im", im_word(0), 32'h01095021);
        chk("single_status", {29'd0, done, busy, cpu_rst}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("single_wc", {28'd0, word_cnt}, 32'd1);

        // Reload from RUN, three words with s_valid toggling
        pulse_start();
        chk("reload_status", {29'd0, cpu_rst, done, s_ready}, {29'd0, 1'b1, 1'b0, 1'b1});
        chk("reload_wc", {28'd0, word_cnt}, 32'd0);
        send(32'hA1B2C3D4, 1'b0, 1'b1);
        send(32'h11223344, 1'b0, 1'b1);
        send(32'hDEADBEEF, 1'b1, 1'b1);
        wait_done();
        drain();
        chk("three_wc", {28'd0, word_cnt}, 32'd3);
        chk("three_w0", im_word(0), 32'hA1B2C3D4);
        chk("three_w1", im_word(4), 32'h11223344);
        chk("three_w2", im_word(8), 32'hDEADBEEF);

        // start during WRITE is ignored; s_valid held across the write burst
        pulse_start();
        send(32'h00000001, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(32'hFFFFFFFF, 1'b1, 1'b0);
        wait_done();
        drain();
        chk("ignore_start_wc", {28'd0, word_cnt}, 32'd2);
        chk("ignore_start_w1", im_word(4), 32'hFFFFFFFF);
`ifdef IM_LOADER_CHECKSUM_EN
        chk("checksum_wrap", checksum, 32'h0);
`endif

        pulse_start();
        send(32'h00000010, 1'b0, 1'b0);
        send(32'h00000020, 1'b1, 1'b1);
        wait_done();
        drain();
        chk("sum_load_w0", im_word(0), 32'h00000010);
`ifdef IM_LOADER_CHECKSUM_EN
        chk("checksum_add", checksum, 32'h30);
`endif

        // Overflow: four words without last fill the memory, fifth never accepted
        pulse_start();
        send(32'h10000001, 1'b0, 1'b0);
        send(32'h20000002, 1'b0, 1'b0);
        send(32'h30000003, 1'b0, 1'b0);
        send(32'h40000004, 1'b0, 1'b0);
        drain();
        s_valid = 1'b1;
        s_data  = 32'h55555555;
        rd = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_ready) rd++;
        end
        s_valid = 1'b0;
        chk("ovf_never_ready", 32'(rd), 32'd0);
        chk("ovf_status", {28'd0, overflow, cpu_rst, busy, done}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("ovf_wc", {28'd0, word_cnt}, 32'd4);
        chk("ovf_last_word", im_word(12), 32'h40000004);
        pulse_start();
        chk("ovf_cleared", {30'd0, overflow, s_ready}, {30'd0, 1'b0, 1'b1});

        // Reset during WRITE of word 2, then reload
        send(32'h0BADF00D, 1'b0, 1'b0);
        send(32'h87654321, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        q_exp.delete();
        chk("midload_reset_outputs",
            {10'd0, s_ready, im_we, im_addr, im_wbyte, cpu_rst, busy, done, overflow, word_cnt},
            {10'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
        chk("partial_byte_kept", {24'd0, im[4]}, 32'h87);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        send(32'hCAFEF00D, 1'b1, 1'b0);
        wait_done();
        drain();
        chk("reload_after_reset_im", im_word(0), 32'hCAFEF00D);
        chk("reload_after_reset_wc", {28'd0, word_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
